// File: rtl/if_id_stage.sv
// Front-end stage: PC register, IF/ID pipeline register, stall/flush FSM and
// counters, plus sticky flags for misuse of the hazard-unit stall interface.
module if_id_stage #(
    parameter int unsigned ADDR_W    = 19,
    parameter int unsigned INSTR_W   = 19,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MAX_STALL = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PCwrite,
    input  logic               IF_IDwrite,
    input  logic               hazard,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] ID_instr,
    output logic [ADDR_W-1:0]  ID_pc,
    output logic               ID_valid,
    output logic [2:0]         IF_rs,
    output logic [2:0]         IF_rt,
    output logic               bubble_out,
    output logic [1:0]         stage_state,
    output logic [CNT_W-1:0]   stall_count,
    output logic [CNT_W-1:0]   flush_count,
    output logic               protocol_err,
    output logic               stall_timeout
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Run length only needs to reach MAX_STALL+1 to detect an over-long stall.
    localparam int unsigned   RUN_W   = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_STALL + 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0]   idpc_q, idpc_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic                perr_q, perr_d;
    logic                tmo_q, tmo_d;
    logic                stall_edge;

    assign stall_edge = hazard & ~branch_taken;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pc_q        <= '0;
            instr_q     <= '0;
            idpc_q      <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            run_q       <= '0;
            perr_q      <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            idpc_q      <= idpc_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            run_q       <= run_d;
            perr_q      <= perr_d;
            tmo_q       <= tmo_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = RUN;
        if (branch_taken) begin
            state_d = FLUSH;
        end else if (hazard) begin
            state_d = STALL;
        end

        pc_d = pc_q;
        if (branch_taken) begin
            pc_d = branch_target;
        end else if (PCwrite) begin
            pc_d = pc_q + ADDR_W'(1);
        end

        instr_d = instr_q;
        idpc_d  = idpc_q;
        valid_d = valid_q;
        if (branch_taken) begin
            instr_d = '0;
            idpc_d  = '0;
            valid_d = 1'b0;
        end else if (IF_IDwrite) begin
            instr_d = imem_data;
            idpc_d  = pc_q;
            valid_d = 1'b1;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_edge && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        flush_cnt_d = flush_cnt_q;
        if (branch_taken && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end

        run_d = '0;
        if (stall_edge) begin
            run_d = (run_q == RUN_SAT) ? run_q : run_q + RUN_W'(1);
        end

        // run_q + 1 > MAX_STALL, written without widening the counter
        tmo_d  = tmo_q | (stall_edge & (32'(run_q) >= MAX_STALL));
        perr_d = perr_q | (PCwrite != IF_IDwrite) | (hazard != ~PCwrite);
    end

    // Output logic
    always_comb begin
        stage_state   = state_q;
        bubble_out    = hazard | branch_taken;
        imem_addr     = pc_q;
        ID_instr      = instr_q;
        ID_pc         = idpc_q;
        ID_valid      = valid_q;
        IF_rs         = instr_q[11:9];
        IF_rt         = instr_q[8:6];
        stall_count   = stall_cnt_q;
        flush_count   = flush_cnt_q;
        protocol_err  = perr_q;
        stall_timeout = tmo_q;
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed walk through the front-end scenarios, then
// randomized traffic compared against a cycle-level arithmetic model.
module tb_if_id_stage;

    localparam int unsigned ADDR_W    = 19;
    localparam int unsigned INSTR_W   = 19;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned MAX_STALL = 2;
    localparam int          AMASK     = 32'h7FFFF;
    localparam int          CMAX      = 15;

    logic               clk = 1'b0;
    logic               rst, PCwrite, IF_IDwrite, hazard, branch_taken;
    logic [ADDR_W-1:0]  branch_target;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] ID_instr;
    logic [ADDR_W-1:0]  ID_pc;
    logic               ID_valid, bubble_out, protocol_err, stall_timeout;
    logic [2:0]         IF_rs, IF_rt;
    logic [1:0]         stage_state;
    logic [CNT_W-1:0]   stall_count, flush_count;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int m_pc, m_instr, m_idpc, m_valid, m_state, m_stall, m_flush, m_run, m_perr, m_tmo;

    if_id_stage #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .CNT_W    (CNT_W),
        .MAX_STALL(MAX_STALL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .PCwrite      (PCwrite),
        .IF_IDwrite   (IF_IDwrite),
        .hazard       (hazard),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .ID_instr     (ID_instr),
        .ID_pc        (ID_pc),
        .ID_valid     (ID_valid),
        .IF_rs        (IF_rs),
        .IF_rt        (IF_rt),
        .bubble_out   (bubble_out),
        .stage_state  (stage_state),
        .stall_count  (stall_count),
        .flush_count  (flush_count),
        .protocol_err (protocol_err),
        .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    function automatic int mem_word(input int a);
        return (32'h10000 + a) & AMASK;
    endfunction

    // combinational instruction memory
    always_comb imem_data = INSTR_W'(mem_word(32'(imem_addr)));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic model_edge();
        int n_pc, n_instr, n_idpc, n_valid;
        if (rst) begin
            m_pc = 0; m_instr = 0; m_idpc = 0; m_valid = 0; m_state = 0;
            m_stall = 0; m_flush = 0; m_run = 0; m_perr = 0; m_tmo = 0;
            return;
        end
        n_pc = branch_taken ? 32'(branch_target) : (PCwrite ? ((m_pc + 1) & AMASK) : m_pc);
        n_instr = m_instr; n_idpc = m_idpc; n_valid = m_valid;
        if (branch_taken) begin
            n_instr = 0; n_idpc = 0; n_valid = 0;
        end else if (IF_IDwrite) begin
            n_instr = mem_word(m_pc); n_idpc = m_pc; n_valid = 1;
        end
        m_state = branch_taken ? 2 : (hazard ? 1 : 0);
        if (hazard && !branch_taken && m_stall < CMAX) m_stall++;
        if (branch_taken && m_flush < CMAX) m_flush++;
        if (hazard && !branch_taken) begin
            m_run++;
            if (m_run > MAX_STALL) m_tmo = 1;
        end else begin
            m_run = 0;
        end
        if (PCwrite != IF_IDwrite || hazard == PCwrite) m_perr = 1;
        m_pc = n_pc; m_instr = n_instr; m_idpc = n_idpc; m_valid = n_valid;
    endtask

    task automatic check_all();
        check("imem_addr",     32'(imem_addr),     m_pc);
        check("ID_instr",      32'(ID_instr),      m_instr);
        check("ID_pc",         32'(ID_pc),         m_idpc);
        check("ID_valid",      32'(ID_valid),      m_valid);
        check("IF_rs",         32'(IF_rs),         (m_instr >> 9) & 7);
        check("IF_rt",         32'(IF_rt),         (m_instr >> 6) & 7);
        check("stage_state",   32'(stage_state),   m_state);
        check("stall_count",   32'(stall_count),   m_stall);
        check("flush_count",   32'(flush_count),   m_flush);
        check("protocol_err",  32'(protocol_err),  m_perr);
        check("stall_timeout", 32'(stall_timeout), m_tmo);
    endtask

    task automatic drive(input logic r, input logic pw, input logic iw, input logic hz,
                         input logic bt, input int tgt);
        rst = r; PCwrite = pw; IF_IDwrite = iw; hazard = hz; branch_taken = bt;
        branch_target = ADDR_W'(tgt);
    endtask

    // one clock: bubble_out checked before the edge, everything else after
    task automatic step();
        #1;
        check("bubble_out", 32'(bubble_out), 32'(hazard | branch_taken));
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(posedge clk); #1;
        step();
        check("rst_pc", 32'(imem_addr), 0);
        check("rst_valid", 32'(ID_valid), 0);

        // free run: fetch 0..3, then one more edge to reach PC=5
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
            step();
        end
        check("t1_instr", 32'(ID_instr), 32'h10003);
        check("t1_idpc", 32'(ID_pc), 3);
        check("t1_pc", 32'(imem_addr), 4);
        step();
        check("t1_pc5", 32'(imem_addr), 5);

        // single-cycle load-use stall
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        step();
        check("t2_pc_hold", 32'(imem_addr), 5);
        check("t2_state", 32'(stage_state), 1);
        check("t2_stall_cnt", 32'(stall_count), 1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        step();
        check("t2_state_run", 32'(stage_state), 0);
        check("t2_perr", 32'(protocol_err), 0);

        // branch beats a simultaneous stall
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
        step();
        check("t3_pc", 32'(imem_addr), 32'h100);
        check("t3_valid", 32'(ID_valid), 0);
        check("t3_state", 32'(stage_state), 2);
        check("t3_flush_cnt", 32'(flush_count), 1);
        check("t3_stall_cnt", 32'(stall_count), 1);

        // PC wrap
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h7FFFF);
        step();
        check("t4_pc_max", 32'(imem_addr), 32'h7FFFF);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        step();
        check("t4_pc_wrap", 32'(imem_addr), 0);
        check("t4_idpc_max", 32'(ID_pc), 32'h7FFFF);
        step();
        check("t4_pc_1", 32'(imem_addr), 1);

        // stall held three edges
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        step();
        step();
        check("t5_tmo_2nd", 32'(stall_timeout), 0);
        step();
        check("t5_tmo_3rd", 32'(stall_timeout), 1);
        check("t5_perr_clean", 32'(protocol_err), 0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        step();
        check("t5_perr_set", 32'(protocol_err), 1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        step();
        check("t5_perr_sticky", 32'(protocol_err), 1);

        // reset in the middle of a stall
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        step();
        check("t6_pc", 32'(imem_addr), 0);
        check("t6_state", 32'(stage_state), 0);
        check("t6_tmo", 32'(stall_timeout), 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        step();
        check("t6_idpc", 32'(ID_pc), 0);
        check("t6_instr", 32'(ID_instr), 32'h10000);

        // randomized traffic; branches frequent enough to saturate the counters
        for (int i = 0; i < 400; i++) begin
            int r, k, tgt;
            r   = int'($urandom_range(0, 99));
            k   = int'($urandom_range(0, 99));
            tgt = (k < 10) ? 32'h7FFFF : int'($urandom & 32'h7FFFF);
            if (r < 2)       drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, tgt);
            else if (r < 30) drive(1'b0, 1'b0, 1'b0, 1'b1, (k < 20), tgt);
            else if (r < 36) drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), (k < 20), tgt);
            else             drive(1'b0, 1'b1, 1'b1, 1'b0, (k < 25), tgt);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Front-end pipeline stage that owns the PC register and the IF/ID pipeline register.
- Consumes the stall controls from the load-use hazard unit (PCwrite, IF_IDwrite, hazard) and a taken-branch redirect from EX.
- Returns decoded rs/rt fields to the hazard unit.
- Tracks stall and flush activity, and flags protocol violations on the stall interface.

Parameters:
ADDR_W, 19, PC and instruction-memory address width (word addressed)
INSTR_W, 19, instruction width
CNT_W, 16, width of the saturating stall and flush counters
MAX_STALL, 2, maximum legal number of consecutive hazard cycles

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
PCwrite  input  1  from hazard unit; 1 = PC may advance
IF_IDwrite  input  1  from hazard unit; 1 = IF/ID may load
hazard  input  1  from hazard unit; load-use stall this cycle
branch_taken  input  1  from EX; redirect and flush
branch_target  input  ADDR_W  redirect address
imem_addr  output  ADDR_W  equals the PC register
imem_data  input  INSTR_W  instruction at imem_addr, same cycle (combinational memory)
ID_instr  output  INSTR_W  IF/ID instruction
ID_pc  output  ADDR_W  IF/ID PC
ID_valid  output  1  IF/ID holds a real instruction
IF_rs  output  3  ID_instr[11:9], to hazard unit
IF_rt  output  3  ID_instr[8:6], to hazard unit
bubble_out  output  1  to ID/EX; zero control fields on next edge
stage_state  output  2  FSM state: 0 RUN, 1 STALL, 2 FLUSH
stall_count  output  CNT_W  saturating count of stall cycles
flush_count  output  CNT_W  saturating count of branch flushes
protocol_err  output  1  sticky stall-interface violation
stall_timeout  output  1  sticky; hazard held longer than MAX_STALL

Behaviour:
Reset (rst=1 at an edge):
- PC = 0; ID_instr = 0 (NOP); ID_pc = 0; ID_valid = 0.
- stage_state = RUN; both counters = 0; both sticky flags = 0; internal run-length counter = 0.
- Reset overrides every other input, including mid-stall and mid-flush.

PC update (priority order):
1. branch_taken: PC <= branch_target.
2. PCwrite: PC <= PC + 1, wrapping modulo 2^ADDR_W (0x7FFFF -> 0).
3. Otherwise hold.

IF/ID update (priority order):
1. branch_taken: ID_instr <= 0, ID_pc <= 0, ID_valid <= 0 (flush).
2. IF_IDwrite: ID_instr <= imem_data, ID_pc <= PC, ID_valid <= 1.
3. Otherwise hold all three.

Combinational outputs:
- bubble_out = hazard | branch_taken, with no register delay.
- IF_rs and IF_rt are always driven from ID_instr, including when ID_valid = 0.

FSM, evaluated each edge:
- branch_taken -> FLUSH (highest priority).
- else hazard -> STALL.
- else -> RUN.
- FLUSH lasts one cycle unless branch_taken repeats.
- Branch during a stall: state goes to FLUSH and the stall is abandoned.

Counters:
- stall_count += 1 on each edge with hazard=1 and branch_taken=0.
- flush_count += 1 on each edge with branch_taken=1.
- Both saturate at 2^CNT_W - 1.

Run-length and stall_timeout:
- The run-length counter increments on hazard=1 and clears on hazard=0 or branch_taken=1.
- stall_timeout sets when the run-length would exceed MAX_STALL.

protocol_err sets on any edge (outside reset) where either holds:
- PCwrite != IF_IDwrite;
- hazard != ~PCwrite.

Test Plan:
1. Reset, then 4 cycles with PCwrite=IF_IDwrite=1, hazard=0, imem_data = 0x10000+addr -> imem_addr 0,1,2,3,4; ID_instr 0x10003 with ID_pc 3 after the 4th edge; ID_valid=1; stage_state RUN.
2. Load-use stall: at PC=5 drive hazard=1, PCwrite=IF_IDwrite=0 for 1 cycle -> PC holds 5; ID_instr/ID_pc hold; bubble_out=1 in that cycle; stage_state STALL then RUN; stall_count=1; no error flags.
3. Branch flush: branch_taken=1, branch_target=0x00100, simultaneously with hazard=1 -> PC=0x00100; ID_valid=0; ID_instr=0; stage_state FLUSH; flush_count=1; stall_count unchanged.
4. Wrap-around: branch to 0x7FFFF, then free-run 2 cycles -> PC goes 0x7FFFF, 0x00000, 0x00001.
5. Violations:
   - PCwrite=0 with IF_IDwrite=1 -> protocol_err=1 and stays set.
   - hazard held 3 consecutive cycles with MAX_STALL=2 -> stall_timeout=1 on the 3rd edge.
6. Reset mid-stall: during hazard=1, assert rst for one edge -> all outputs return to reset values; next free-run cycle fetches address 0.
